// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key 2-flop sync + debounce, press/release pulses, press counter.
// Optional auto-repeat of held keys is built only when KEY_AUTOREPEAT_EN is defined.

module key_conditioner_lane #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1, r_sync2, r_stable, r_press, r_release;
    logic [CW-1:0] r_cnt;
    logic          w_s, w_diff, w_done, w_rhit;

    assign w_s    = ~r_sync2;
    assign w_diff = w_s ^ r_stable;
    assign w_done = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] r_rcnt;
    logic          r_rfirst;

    // A release edge (w_done while held) must never coincide with a repeat pulse.
    assign w_rhit = r_stable && !w_done &&
                    (r_rcnt == (r_rfirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rcnt   <= '0;
            r_rfirst <= 1'b1;
        end else if (w_done || !r_stable) begin
            r_rcnt   <= '0;
            r_rfirst <= 1'b1;
        end else if (w_rhit) begin
            r_rcnt   <= '0;
            r_rfirst <= 1'b0;
        end else begin
            r_rcnt   <= r_rcnt + 1'b1;
        end
    end
`else
    assign w_rhit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_press   <= (w_done && !r_stable) || w_rhit;
            r_release <= w_done && r_stable;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt    <= '0;
                r_stable <= ~r_stable;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;
endmodule

module key_conditioner #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [7:0]        press_count
);
    logic [7:0] r_count;
    logic [7:0] w_inc;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
        key_conditioner_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_lane (
            .i_clk    (CLOCK_50),
            .i_rst    (reset),
            .i_key_n  (key_n_in[g]),
            .o_level  (key_level[g]),
            .o_press  (key_press[g]),
            .o_release(key_release[g])
        );
    end

    // Count the registered pulses, so the total lags key_press by one edge.
    always_comb begin
        w_inc = '0;
        for (int k = 0; k < N_KEYS; k++) w_inc = w_inc + {7'd0, key_press[k]};
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_count <= '0;
        else       r_count <= r_count + w_inc;
    end

    assign press_count = r_count;
endmodule
